pipe_stage_buf: RTL
===================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline buffer for the pipelined RISC-V datapath (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
//  Holds up to DEPTH stage packets in a circular buffer, each packet being a control field plus a data field.
//  Uses a valid/ready handshake on both sides, so the CPU stalls by back-pressure instead of per-latch enables.
//  Also provides flush, bubble output when empty, a sticky halt latch and a saturating stall counter.
// PARAMETERS
//  DW        32  data payload width (PC, instr, rdat1, rdat2, imm concatenated by the user)
//  CTRLW     16  control field width (WEN, memtoreg, dmemr/w, aluop, ...)
//  DEPTH      2  buffer entries, 1..8; any value, power of two not required
//  HALT_BIT   0  index within ctrl of the halt flag
//  STALLW     8  stall counter width
// PORTS
//  CLK        in   1        system clock, rising edge
//  RST        in   1        synchronous reset, active-high
//  flush      in   1        discard all held entries and the same-cycle enqueue
//  in_valid   in   1        upstream presents a packet
//  in_ready   out  1        buffer can accept a packet
//  in_ctrl    in   CTRLW    upstream control field
//  in_data    in   DW       upstream data field
//  out_valid  out  1        head packet valid
//  out_ready  in   1        downstream consumes head
//  out_ctrl   out  CTRLW    head control field; 0 when empty (bubble)
//  out_data   out  DW       head data field; 0 when empty
//  count      out  4        entries held, 0..DEPTH
//  halted     out  1        sticky: a halt packet has been dequeued
//  stall_cnt  out  STALLW   cycles with in_valid & !in_ready, saturating
// BEHAVIOUR
//  Reset (RST=1 at an edge)
//   - count=0, rd/wr pointers=0, halted=0, stall_cnt=0.
//   - Following from count=0: out_valid=0, out_ctrl=0, out_data=0.
//   - Storage contents are don't-care.
//   - RST overrides flush, enqueue and dequeue in the same cycle.
//  Handshake
//   - in_ready = (count<DEPTH) & !halted. No combinational path from out_ready to in_ready.
//   - out_valid = (count!=0). out_ctrl and out_data are driven from the head entry, gated to 0 when empty.
//   - enq = in_valid & in_ready & !flush; deq = out_valid & out_ready.
//  Latency and throughput
//   - A packet enqueued at edge t appears on out_* after that edge, i.e. one cycle of latency.
//   - With DEPTH>=2 a full-rate stream is sustained: at count<DEPTH, enq and deq happen together and count is unchanged.
//   - With DEPTH=1 throughput is 1/2 (full blocks enq), which is the intended plain-latch mode.
//  Pointers
//   - wr_ptr and rd_ptr advance on enq and deq respectively, wrapping from DEPTH-1 to 0.
//   - count += enq - deq.
//  Flush
//   - next count=0 and both pointers=0.
//   - An in_valid packet in the flush cycle is dropped and not counted as a stall.
//   - out_valid and the head stay visible during the flush cycle. A deq in that cycle is legal and updates halted.
//  Halt
//   - On deq with out_ctrl[HALT_BIT]=1, halted<=1 at the next edge.
//   - While halted: in_ready=0 and no new packets enter. Remaining entries still drain.
//   - halted is cleared only by RST; flush does not clear it.
//  Stall counter
//   - Increments when in_valid & !in_ready & !flush; holds at 2^STALLW-1.
//  Boundaries
//   - Full (count=DEPTH): no enqueue even if out_ready=1 in the same cycle.
//   - Empty: out_ready is ignored and no deq occurs.
//   - count never exceeds DEPTH and never underflows; the bench asserts both.
// TESTING
//  1 DEPTH=2, stream data 1..8 with out_ready=1 -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
//  2 out_ready=0, present 3 packets -> 2 accepted, count=2, in_ready=0, stall_cnt counts 1 per blocked cycle;
//    then out_ready=1 -> order preserved.
//  3 count=2 plus in_valid=1 with flush=1 -> next cycle count=0, out_valid=0, out_ctrl=out_data=0, new packet lost.
//  4 Enqueue ctrl with bit HALT_BIT set, then dequeue -> halted=1 next cycle, in_ready=0 until RST, queued packets still drain.
//  5 DEPTH=3, 20 packets with random out_ready -> in-order delivery across pointer wrap, count always <=3.
//  6 RST asserted mid-stream at count=2, halted=1, stall_cnt=5 -> next cycle all zero and in_ready=1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: circular queue of {ctrl, data} packets with valid/ready
// handshake on both sides, flush, bubble-on-empty, sticky halt latch and saturating stall counter.
module pipe_stage_buf #(
    parameter int DW       = 32,
    parameter int CTRLW    = 16,
    parameter int DEPTH    = 2,
    parameter int HALT_BIT = 0,
    parameter int STALLW   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRLW-1:0]  in_ctrl,
    input  logic [DW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRLW-1:0]  out_ctrl,
    output logic [DW-1:0]     out_data,
    output logic [3:0]        count,
    output logic              halted,
    output logic [STALLW-1:0] stall_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CTRLW-1:0]  r_ctrl_mem [DEPTH];
    logic [DW-1:0]     r_data_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [3:0]        r_count;
    logic              r_halted;
    logic [STALLW-1:0] r_stall_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_enq;
    logic              w_deq;
    logic              w_blocked;
    logic [AW-1:0]     w_wr_next;
    logic [AW-1:0]     w_rd_next;
    logic [3:0]        w_count_next;

    // in_ready depends only on registered state, so out_ready never reaches it combinationally.
    assign w_in_ready  = (r_count < 4'(DEPTH)) && !r_halted;
    assign w_out_valid = (r_count != 4'd0);
    assign w_enq       = in_valid && w_in_ready && !flush;
    assign w_deq       = w_out_valid && out_ready;
    assign w_blocked   = in_valid && !w_in_ready && !flush;
    assign w_wr_next   = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next   = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        w_count_next = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_next = r_count + 4'd1;
            2'b01:   w_count_next = r_count - 4'd1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: storage has no reset; the count gates visibility, so contents after reset are don't-care.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_ctrl_mem[r_wr_ptr] <= in_ctrl;
            r_data_mem[r_wr_ptr] <= in_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values in parallel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= 4'd0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_deq && r_ctrl_mem[r_rd_ptr][HALT_BIT]) begin
                r_halted <= 1'b1;
            end
            if (w_blocked && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= 4'd0;
            end else begin
                if (w_enq) r_wr_ptr <= w_wr_next;
                if (w_deq) r_rd_ptr <= w_rd_next;
                r_count <= w_count_next;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_ctrl_mem[r_rd_ptr] : '0;
    assign out_data  = w_out_valid ? r_data_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;

endmodule
